// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants and types for the multi-channel PWM.
//   - write-port address map (period, per-channel duty, ctrl)
//   - counter mode enum and the ctrl-register bit index
package pwm_pkg;

    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_DUTY0  = 5'd1;

    // Bit of the ctrl register selecting centre-aligned counting.
    localparam int CTRL_CENTER = 0;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // The ctrl register sits right after the last duty register.
    function automatic logic [ADDR_W-1:0] ADDR_CTRL(input int n_ch);
        return ADDR_W'(n_ch + 1);
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM channel.
//   Holds the duty shadow/active pair, compares the shared counter against
//   the active duty and registers the result with optional inversion.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable; output parks at the inactive level when low
//   wr            duty shadow write strobe (already decoded by the top)
//   xfer          shadow -> active copy strobe
//   wr_data       duty value to write
//   cnt           shared period counter
//   pwm_out       registered channel output
module pwm_chan #(
    parameter int   CNT_W = 16,
    parameter logic INV   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic             xfer,
    input  logic [CNT_W-1:0] wr_data,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_s;
    logic [CNT_W-1:0] duty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_s  <= '0;
            duty_q  <= '0;
            pwm_out <= INV;
        end else begin
            if (wr)
                duty_s <= wr_data;
            // Copy takes the pre-write shadow when both happen together,
            // so a write on the boundary cycle waits for the next boundary.
            if (xfer)
                duty_q <= duty_s;
            pwm_out <= en ? ((cnt < duty_q) ^ INV) : INV;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N_CH-channel PWM generator sharing one period counter.
//   Edge-aligned (0..per, period per+1) or centre-aligned (up/down,
//   period 2*per) counting. Configuration writes land in shadow registers
//   and move to the active set at a period boundary or while disabled.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            run enable
//   wr_en         single-cycle write strobe
//   wr_addr       0 = period, 1..N_CH = duty, N_CH+1 = ctrl (bit0 centre)
//   wr_data       write data
//   pwm_out       registered PWM outputs (INV_MASK bits active-low)
//   period_tick   pulse on the last cycle of each period
//   upd_pending   shadow holds values not yet transferred
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int              N_CH     = 4,
    parameter int              CNT_W    = 16,
    parameter logic [N_CH-1:0] INV_MASK = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CNT_W-1:0]  wr_data,
    output logic [N_CH-1:0]   pwm_out,
    output logic              period_tick,
    output logic              upd_pending
);

    logic [CNT_W-1:0] per_s, per_q;
    pwm_mode_e        mode_s, mode_q;
    logic [CNT_W-1:0] cnt;
    logic             dir;          // 1 = counting down (centre mode only)

    logic             wr_per, wr_ctrl, wr_valid;
    logic [N_CH-1:0]  wr_duty;
    logic             center;
    logic             xfer;

    // Write decode; out-of-map addresses match nothing and are dropped.
    always_comb begin
        wr_per  = wr_en && (wr_addr == ADDR_PERIOD);
        wr_ctrl = wr_en && (wr_addr == ADDR_CTRL(N_CH));
        for (int i = 0; i < N_CH; i++)
            wr_duty[i] = wr_en && (wr_addr == ADDR_DUTY0 + ADDR_W'(i));
        wr_valid = wr_per | wr_ctrl | (|wr_duty);
    end

    // A centre period of 1 or less degenerates to edge counting.
    assign center      = (mode_q == PWM_CENTER) && (per_q > CNT_W'(1));
    assign period_tick = en && (center ? (dir && (cnt == CNT_W'(1)))
                                       : (cnt == per_q));
    assign xfer        = !en || period_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            per_s       <= '0;
            per_q       <= '0;
            mode_s      <= PWM_EDGE;
            mode_q      <= PWM_EDGE;
            upd_pending <= 1'b0;
        end else begin
            if (wr_per)
                per_s <= wr_data;
            if (wr_ctrl)
                mode_s <= pwm_mode_e'(wr_data[CTRL_CENTER]);
            if (xfer) begin
                per_q  <= per_s;
                mode_q <= mode_s;
            end
            // A write on the transfer edge still differs from the new active.
            if (wr_valid)
                upd_pending <= 1'b1;
            else if (xfer)
                upd_pending <= 1'b0;
        end
    end

    // Every boundary leaves cnt=0/dir=up in both modes, so a mode change
    // taking effect at the boundary always starts cleanly.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
            dir <= 1'b0;
        end else if (center) begin
            if (!dir) begin
                if (cnt == per_q) begin
                    cnt <= cnt - CNT_W'(1);
                    dir <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (cnt == CNT_W'(1)) begin
                cnt <= '0;
                dir <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end else begin
            cnt <= (cnt == per_q) ? '0 : cnt + CNT_W'(1);
            dir <= 1'b0;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pwm_chan #(
            .CNT_W (CNT_W),
            .INV   (INV_MASK[i])
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .wr      (wr_duty[i]),
            .xfer    (xfer),
            .wr_data (wr_data),
            .cnt     (cnt),
            .pwm_out (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: scoreboard bench for pwm_multi (4 channels, ch1 inverted).
// Expected outputs are pushed when a cycle's stimulus is driven and popped
// at the following falling edge, where the DUT outputs are compared.
module tb_pwm_multi;

    localparam logic [3:0] INV = 4'b0010;

    typedef struct packed {
        logic [3:0] pwm;
        logic       tick;
        logic       pend;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  pwm_out;
    logic        period_tick;
    logic        upd_pending;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    pwm_multi #(
        .N_CH     (4),
        .CNT_W    (16),
        .INV_MASK (INV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .upd_pending (upd_pending)
    );

    // Output level for a counter value given the four duties.
    function automatic logic [3:0] exp_pwm(input int cv, input int d0, input int d1,
                                           input int d2, input int d3);
        logic [3:0] r;
        r[0] = (cv < d0);
        r[1] = (cv < d1);
        r[2] = (cv < d2);
        r[3] = (cv < d3);
        return r ^ INV;
    endfunction

    task automatic wr(input logic [4:0] a, input int d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = 16'(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            // k=0: rst held two cycles; k=1: one idle cycle after release
            sb.push_back('{pwm: INV, tick: 1'b0, pend: 1'b0});
            if (k == 0) begin
                @(negedge clk);
                @(negedge clk);
            end else begin
                rst = 1'b0;
                @(negedge clk);
            end
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL reset k=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         k, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
    endtask

    task automatic test_edge_basic;
        exp_t e;
        wr(5'd0, 9);
        wr(5'd1, 0);
        wr(5'd2, 3);
        wr(5'd3, 10);
        wr(5'd4, 5);
        wr(5'd5, 0);
        // last write is in shadow, not yet transferred
        sb.push_back('{pwm: INV, tick: 1'b0, pend: 1'b1});
        e = sb.pop_front();
        n_cmp++;
        if (upd_pending !== e.pend) begin
            n_bad++;
            $display("FAIL edge_pend_set: got pend=%b, expected %b", upd_pending, e.pend);
        end
        sb.push_back('{pwm: INV, tick: 1'b0, pend: 1'b0});
        @(negedge clk);
        e = sb.pop_front();
        n_cmp++;
        if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL edge_idle: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                     pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
        end
        for (int c = 0; c < 30; c++) begin
            en = 1'b1;
            sb.push_back('{pwm: exp_pwm(c % 10, 0, 3, 10, 5),
                           tick: ((c + 1) % 10 == 9), pend: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL edge_basic c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
    endtask

    task automatic test_glitch_free;
        exp_t e;
        for (int c = 0; c < 20; c++) begin
            wr_en   = (c == 4);
            wr_addr = 5'd2;
            wr_data = 16'd7;
            sb.push_back('{pwm: exp_pwm(c % 10, 0, (c < 10) ? 3 : 7, 10, 5),
                           tick: ((c + 1) % 10 == 9), pend: (c >= 4 && c <= 8)});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL glitch_free c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_tick_write;
        exp_t e;
        for (int c = 0; c < 30; c++) begin
            wr_en   = (c == 9);
            wr_addr = 5'd2;
            wr_data = 16'd2;
            sb.push_back('{pwm: exp_pwm(c % 10, 0, (c < 20) ? 7 : 2, 10, 5),
                           tick: ((c + 1) % 10 == 9), pend: (c >= 9 && c <= 18)});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL tick_write c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_center;
        exp_t e;
        int   seq [8] = '{0, 1, 2, 3, 4, 3, 2, 1};
        en = 1'b0;
        wr(5'd0, 4);
        wr(5'd2, 2);
        wr(5'd5, 1);
        wr(5'd7, 16'hffff);     // unmapped: must not raise upd_pending
        sb.push_back('{pwm: INV, tick: 1'b0, pend: 1'b0});
        e = sb.pop_front();
        n_cmp++;
        if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
            n_bad++;
            $display("FAIL center_idle: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                     pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
        end
        for (int c = 0; c < 24; c++) begin
            en = 1'b1;
            sb.push_back('{pwm: exp_pwm(seq[c % 8], 0, 2, 10, 5),
                           tick: ((c + 1) % 8 == 7), pend: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL center c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        en = 1'b0;
        wr(5'd0, 9);
        wr(5'd5, 0);
        @(negedge clk);
        for (int c = 0; c < 6; c++) begin
            en  = (c != 5);
            rst = (c == 5);     // hits while cnt==5
            if (c < 5)
                sb.push_back('{pwm: exp_pwm(c, 0, 2, 10, 5), tick: 1'b0, pend: 1'b0});
            else
                sb.push_back('{pwm: INV, tick: 1'b0, pend: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL reset_mid c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
        // Cleared shadow: period 0 ticks every cycle, duty 0 stays inactive.
        for (int c = 0; c < 8; c++) begin
            rst = 1'b0;
            en  = 1'b1;
            sb.push_back('{pwm: INV, tick: 1'b1, pend: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if ({pwm_out, period_tick, upd_pending} !== {e.pwm, e.tick, e.pend}) begin
                n_bad++;
                $display("FAIL after_reset c=%0d: got pwm=%b tick=%b pend=%b, expected pwm=%b tick=%b pend=%b",
                         c, pwm_out, period_tick, upd_pending, e.pwm, e.tick, e.pend);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_glitch_free();
        test_tick_write();
        test_center();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
